comparator_checker: RTL

- Response-side monitor for the 3-bit "greater than threshold" comparator path (comparator5 class).
- Each cycle it samples the code driven into the comparator and the comparator's result bit, then checks the result against a locally computed expectation.
- Counts samples and mismatches, records which codes have been exercised, and reports pass/fail after a fixed number of samples.
- Synthesizable, so it can sit beside the comparator in silicon or in a bench.

---
 rtl/comparator_pkg.sv | 14 +
 rtl/cmp_ref_model.sv | 20 ++
 rtl/comparator_checker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator5 path: default code width and
// threshold, plus the checker FSM state encoding.
package comparator_pkg;

    localparam int unsigned DEF_WIDTH  = 3;
    localparam int unsigned DEF_THRESH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_ref_model.sv
// Golden expectation for the comparator5 path: expected_c = (code > THRESH).
// Ports:
//   code       - code driven into the comparator
//   expected_c - combinational expected comparator result
module cmp_ref_model
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned THRESH = DEF_THRESH
) (
    input  logic [WIDTH-1:0] code,
    output logic             expected_c
);

    // Compare at 32 bits so a THRESH outside the code range is not truncated.
    always_comb begin
        expected_c = (32'(code) > THRESH);
    end

endmodule

// File: rtl/comparator_checker.sv
// Response-side monitor for the comparator5 path. Checks each accepted
// code/result pair against cmp_ref_model, counts samples and mismatches,
// tracks code coverage and reports pass/fail after NUM_SAMPLES samples.
// Ports:
//   clk, reset      - rising-edge clock, async active-high reset
//   start           - one-cycle pulse, starts a run from IDLE or DONE
//   sample_valid    - code/result pair valid this cycle
//   code, result    - sampled comparator input and output
//   busy, done      - FSM in RUN / DONE
//   pass            - zero mismatches and full coverage, valid while done
//   mismatch        - one-cycle pulse after a failing sample
//   mismatch_cnt    - saturating failing-sample count
//   sample_cnt      - accepted-sample count
//   coverage        - bit i set once code==i has been accepted
//   first_err_code  - code of the first failing sample of the run
module comparator_checker
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned THRESH      = DEF_THRESH,
    parameter int unsigned NUM_SAMPLES = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sample_valid,
    input  logic [WIDTH-1:0]      code,
    input  logic                  result,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  mismatch,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic [CNT_W-1:0]      sample_cnt,
    output logic [(1<<WIDTH)-1:0] coverage,
    output logic [WIDTH-1:0]      first_err_code
);

    localparam int unsigned NCODE = 1 << WIDTH;
    // Run-length counter sized for NUM_SAMPLES, independent of CNT_W,
    // so the run still terminates when the visible counters are narrow.
    localparam int unsigned RUN_W = $clog2(NUM_SAMPLES + 1);

    state_t             state, state_next;
    logic [RUN_W-1:0]   run_cnt, run_cnt_next;
    logic               busy_next, done_next, pass_next, mismatch_next;
    logic [CNT_W-1:0]   mismatch_cnt_next, sample_cnt_next;
    logic [NCODE-1:0]   coverage_next;
    logic [WIDTH-1:0]   first_err_code_next;
    logic               expected_c;
    logic               fail_c;

    cmp_ref_model #(
        .WIDTH  (WIDTH),
        .THRESH (THRESH)
    ) u_ref (
        .code       (code),
        .expected_c (expected_c)
    );

    assign fail_c = (state == ST_RUN) && sample_valid && (result != expected_c);

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            run_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch       <= 1'b0;
            mismatch_cnt   <= '0;
            sample_cnt     <= '0;
            coverage       <= '0;
            first_err_code <= '0;
        end else begin
            state          <= state_next;
            run_cnt        <= run_cnt_next;
            busy           <= busy_next;
            done           <= done_next;
            pass           <= pass_next;
            mismatch       <= mismatch_next;
            mismatch_cnt   <= mismatch_cnt_next;
            sample_cnt     <= sample_cnt_next;
            coverage       <= coverage_next;
            first_err_code <= first_err_code_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next          = state;
        run_cnt_next        = run_cnt;
        pass_next           = pass;
        mismatch_next       = 1'b0;
        mismatch_cnt_next   = mismatch_cnt;
        sample_cnt_next     = sample_cnt;
        coverage_next       = coverage;
        first_err_code_next = first_err_code;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                // A sample arriving alongside start is dropped.
                if (start) begin
                    state_next          = ST_RUN;
                    run_cnt_next        = '0;
                    pass_next           = 1'b0;
                    mismatch_cnt_next   = '0;
                    sample_cnt_next     = '0;
                    coverage_next       = '0;
                    first_err_code_next = '0;
                end
            end
            ST_RUN: begin
                if (sample_valid) begin
                    run_cnt_next        = run_cnt + RUN_W'(1);
                    sample_cnt_next     = sample_cnt + CNT_W'(1);
                    coverage_next[code] = 1'b1;
                    if (fail_c) begin
                        mismatch_next = 1'b1;
                        // Count is zero only before the first fail of a run.
                        if (mismatch_cnt == '0) begin
                            first_err_code_next = code;
                        end
                        if (mismatch_cnt != '1) begin
                            mismatch_cnt_next = mismatch_cnt + CNT_W'(1);
                        end
                    end
                    if (run_cnt_next == RUN_W'(NUM_SAMPLES)) begin
                        state_next = ST_DONE;
                        pass_next  = (mismatch_cnt_next == '0) && (&coverage_next);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_RUN);
        done_next = (state_next == ST_DONE);
    end

endmodule
